// File: rtl/rx_ask4_slicer_ber.sv
// 4-ASK receive slicer with symbol-error counter over a fixed window.
// Optional RX_AVG_MAG_EN adds avg_mag, the mean |sig_in| over the window.
module rx_ask4_slicer_ber #(
  parameter logic signed [17:0] A_LEVEL = 18'sd21845,
  parameter int REF_DELAY = 8,
  parameter int SETTLE_SYMS = 16,
  parameter int WIN_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sam_clk_en,
  input  logic        sym_clk_en,
  input  logic [17:0] sig_in,
  input  logic [1:0]  ref_bits,
  input  logic        meas_start,
  output logic [17:0] sym_out,
  output logic [1:0]  bits_out,
  output logic [20:0] err_count,
  output logic [20:0] sym_count,
`ifdef RX_AVG_MAG_EN
  output logic [17:0] avg_mag,
`endif
  output logic        meas_done
);

  localparam logic signed [17:0] TWO_A = A_LEVEL <<< 1;
  localparam logic signed [17:0] NEG_TWO_A = -TWO_A;
  localparam int SW = $clog2(SETTLE_SYMS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SYMS - 1);
  localparam logic [20:0] WIN = 21'd1 << WIN_LOG2;

  typedef enum logic [1:0] {
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  logic signed [17:0] sig_s;
  logic [1:0]  slice_d;
  logic [17:0] sym_q;
  logic [1:0]  bits_q;
  logic [1:0]  refd_q;
  logic [1:0]  dl_q [REF_DELAY];
  logic        cmp_q;
  logic        err_flag;
  state_t      state_q;
  logic [SW-1:0] settle_q;
  logic [20:0] err_q;
  logic [20:0] symc_q;
  logic        done_q;
  logic        unused_sam;

  assign sig_s = $signed(sig_in);
  assign unused_sam = sam_clk_en;
  assign err_flag = (bits_q != refd_q);

`ifdef RX_AVG_MAG_EN
  localparam int AW = 18 + WIN_LOG2;
  logic [17:0] mag_d;
  logic [17:0] mag_q;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [17:0] avg_q;

  // Magnitude of the symbol sample; the most negative code saturates.
  always_comb begin
    mag_d = sig_in;
    if (sig_s == -18'sd131072) mag_d = 18'd131071;
    else if (sig_s < 18'sd0) mag_d = 18'(-sig_s);
  end

  assign acc_d = acc_q + AW'(mag_q);
  assign avg_mag = avg_q;
`endif

  // Four-level decision against 0 and +/-2a.
  always_comb begin
    slice_d = 2'b00;
    unique case (1'b1)
      (sig_s >= TWO_A):
        slice_d = 2'b11;
      (sig_s >= 18'sd0 && sig_s < TWO_A):
        slice_d = 2'b10;
      (sig_s >= NEG_TWO_A && sig_s < 18'sd0):
        slice_d = 2'b01;
      default:
        slice_d = 2'b00;
    endcase
  end

  // Downsample, slice and shift the reference on each symbol enable.
  // refd_q takes the tap before the shift so it lines up with bits_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_q  <= '0;
      bits_q <= '0;
      refd_q <= '0;
      cmp_q  <= 1'b0;
      for (int i = 0; i < REF_DELAY; i++) dl_q[i] <= 2'b00;
`ifdef RX_AVG_MAG_EN
      mag_q  <= '0;
`endif
    end else begin
      cmp_q <= sym_clk_en;
      if (sym_clk_en) begin
        sym_q  <= sig_in;
        bits_q <= slice_d;
        refd_q <= dl_q[REF_DELAY-1];
        dl_q[0] <= ref_bits;
        for (int i = 1; i < REF_DELAY; i++) dl_q[i] <= dl_q[i-1];
`ifdef RX_AVG_MAG_EN
        mag_q  <= mag_d;
`endif
      end
    end
  end

  // Settle / measure / done sequencing with restart priority.
  always_ff @(posedge clk) begin
    if (reset || meas_start) begin
      state_q  <= SETTLE;
      settle_q <= '0;
      err_q    <= '0;
      symc_q   <= '0;
      done_q   <= 1'b0;
`ifdef RX_AVG_MAG_EN
      acc_q    <= '0;
      avg_q    <= '0;
`endif
    end else if (cmp_q) begin
      unique case (state_q)
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q  <= MEASURE;
            settle_q <= '0;
            err_q    <= '0;
            symc_q   <= '0;
`ifdef RX_AVG_MAG_EN
            acc_q    <= '0;
`endif
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        MEASURE: begin
          symc_q <= symc_q + 21'd1;
          err_q  <= err_q + {20'd0, err_flag};
`ifdef RX_AVG_MAG_EN
          acc_q  <= acc_d;
`endif
          if (symc_q + 21'd1 == WIN) begin
            state_q <= DONE;
            done_q  <= 1'b1;
`ifdef RX_AVG_MAG_EN
            avg_q   <= 18'(acc_d >> WIN_LOG2);
`endif
          end
        end
        DONE: begin
        end
        default: state_q <= SETTLE;
      endcase
    end
  end

  assign sym_out   = sym_q;
  assign bits_out  = bits_q;
  assign err_count = err_q;
  assign sym_count = symc_q;
  assign meas_done = done_q;

endmodule
